seq_divider8: RTL and testbench
===============================

// Module: seq_divider8
// PURPOSE
//   Multi-cycle unsigned restoring divider. It is the inverse-operation
//   companion to the combinational rca8/rcas8 adder-subtractor datapath.
//   Each cycle performs one trial subtraction (WIDTH+1 bits wide) plus a restore step.
//   It sits beside the ALU and is driven by a start/done handshake from the controller.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; iteration count = WIDTH
// PORTS
//   clk          in   1      rising-edge clock, single clock domain
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  unsigned dividend, captured when start is accepted
//   divisor      in   WIDTH  unsigned divisor, captured when start is accepted
//   busy         out  1      high in RUN and DONE states
//   done         out  1      one-cycle pulse: results valid
//   quotient     out  WIDTH  registered quotient, held until next accepted start
//   remainder    out  WIDTH  registered remainder, held until next accepted start
//   div_by_zero  out  1      set with done when divisor==0; held with results
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; all outputs and internal regs = 0.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE, start=1, divisor!=0:
//     - load A=0 (WIDTH+1 bits), Q=dividend, M=divisor, cnt=WIDTH
//     - next state RUN
//   IDLE, start=1, divisor==0:
//     - next state DONE
//     - quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1
//   RUN, each cycle:
//     - shift {A,Q} left by 1
//     - T = A - {1'b0,M}
//     - if T[WIDTH]==1 (negative): keep shifted A, Q[0]=0
//     - else: A=T, Q[0]=1
//     - cnt decrements; after the iteration with cnt==1, state goes to DONE
//     - on that same edge: quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=0
//   DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
//   Latency: start accepted at edge 0 -> done high after edge WIDTH+1 (9 for WIDTH=8).
//     Div-by-zero: done high after edge 1.
//   Throughput: a new start is accepted in the first IDLE cycle after DONE.
//     Minimum spacing between accepted starts is WIDTH+2 cycles.
//   start while busy (RUN or DONE): ignored, no effect on the operation in flight.
//   Operand inputs may change freely after acceptance; only captured values are used.
//   quotient/remainder/div_by_zero are updated only when entering DONE.
//     They are stable at all other times.
//   rst_n asserted mid-operation: operation aborted immediately.
//     Outputs return to 0; no done pulse is produced.
//   Results satisfy: dividend == quotient*divisor + remainder, and remainder < divisor.
// TESTING
//   1 100/7: start at edge 0 -> done after edge 9; quotient=14, remainder=2, dbz=0.
//   2 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0.
//   3 200/0 -> done after edge 1; q=255, r=200, div_by_zero=1.
//   4 start 100/7, then pulse start with 50/5 at edge 3 -> ignored; result is q=14, r=2.
//   5 start 171/13, drop rst_n at edge 4 -> all outputs 0 at once, no done.
//       Then restart -> q=13, r=2.
//   6 Back-to-back: 130/10 then 77/8 issued in first IDLE cycle after done.
//       Results q=13, r=0 then q=9, r=5; done pulses exactly 10 cycles apart.

Source files
------------

// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock; WIDTH+1 cycles from accept to done.
// start is honoured only in IDLE; busy covers RUN and DONE, and done pulses for one cycle with the registered results.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt_q == CW'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

  // One restoring step: shift {A,Q}, trial-subtract M, keep the difference only if it is non-negative.
  assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial   = a_shift - {1'b0, m_q};

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (state_q == IDLE && start) begin
      if (divisor != '0) begin
        a_d   = '0;
        q_d   = dividend;
        m_d   = divisor;
        cnt_d = CW'(WIDTH);
      end else begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (trial[WIDTH]) begin
        a_d = a_shift;
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end else begin
        a_d = trial;
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        quot_d = q_d;
        rem_d  = a_d[WIDTH-1:0];
        dbz_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Bench for seq_divider8: cycle-level reference model plus directed literal cases and random traffic.
module tb_seq_divider8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  seq_divider8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: cycles remaining in the operation; results are published as the pulse begins.
  int           m_left;
  logic [W-1:0] m_pq, m_pr, m_q, m_r;
  logic         m_pdbz, m_dbz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_pq = '0; m_pr = '0; m_pdbz = 1'b0;
      m_q = '0;  m_r = '0;  m_dbz = 1'b0;
    end else begin
      if (m_left == 0) begin
        if (start) begin
          if (divisor == 0) begin
            m_pq = '1; m_pr = dividend; m_pdbz = 1'b1; m_left = 1;
          end else begin
            m_pq = dividend / divisor; m_pr = dividend % divisor; m_pdbz = 1'b0; m_left = W + 1;
          end
          if (m_left == 1) begin m_q = m_pq; m_r = m_pr; m_dbz = m_pdbz; end
        end
      end else begin
        m_left--;
        if (m_left == 1) begin m_q = m_pq; m_r = m_pr; m_dbz = m_pdbz; end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [W-1:0] eq, er;
    logic ebusy, edone, edbz;
    ebusy = (m_left != 0);
    edone = (m_left == 1);
    eq = m_q; er = m_r; edbz = m_dbz;
    checks++;
    if (busy !== ebusy || done !== edone || quotient !== eq || remainder !== er || div_by_zero !== edbz) begin
      errors++;
      $display("FAIL cycle %0d model: busy/done/q/r/dbz got %b/%b/%0d/%0d/%b expected %b/%b/%0d/%0d/%b",
               cyc, busy, done, quotient, remainder, div_by_zero, ebusy, edone, eq, er, edbz);
    end
  end

  // Issue one op and wait (bounded) for done; optionally inject a start with 50/5 after inj edges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int eq, input int er,
                        input int edbz, input int elat, input int inj, input string name);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == inj) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
      end
      if (done) begin seen = 1'b1; last_done_cyc = cyc; end
    end
    chk({name, " done_seen"}, int'(seen), 1);
    chk({name, " latency"}, n, elat);
    chk({name, " quotient"}, int'(quotient), eq);
    chk({name, " remainder"}, int'(remainder), er);
    chk({name, " dbz"}, int'(div_by_zero), edbz);
  endtask

  initial begin
    int t0;
    bit saw_done;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset dbz", int'(div_by_zero), 0);
    #2 rst_n = 1'b1;

    run_op(8'd100, 8'd7, 14, 2, 0, 9, 0, "100/7");
    run_op(8'd255, 8'd1, 255, 0, 0, 9, 0, "255/1");
    run_op(8'd5, 8'd9, 0, 5, 0, 9, 0, "5/9");
    run_op(8'd0, 8'd3, 0, 0, 0, 9, 0, "0/3");
    run_op(8'd200, 8'd0, 255, 200, 1, 1, 0, "200/0");
    run_op(8'd100, 8'd7, 14, 2, 0, 9, 3, "100/7 with start while busy");

    // Abort mid-operation with reset, then rerun.
    @(negedge clk);
    start = 1'b1; dividend = 8'd171; divisor = 8'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort quotient", int'(quotient), 0);
    chk("abort remainder", int'(remainder), 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort no done", int'(saw_done), 0);
    #2 rst_n = 1'b1;
    run_op(8'd171, 8'd13, 13, 2, 0, 9, 0, "171/13 after abort");

    run_op(8'd130, 8'd10, 13, 0, 0, 9, 0, "130/10");
    t0 = last_done_cyc;
    run_op(8'd77, 8'd8, 9, 5, 0, 9, 0, "77/8 back-to-back");
    chk("done spacing", last_done_cyc - t0, 10);

    // Random traffic: starts at arbitrary times, including while busy, some zero divisors.
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
